// File: rtl/lfsr20_pkg.sv
// Shared definitions for the 20-bit XNOR Galois LFSR pattern: step function,
// lock-up word and checker state encoding.
package lfsr20_pkg;

   localparam logic [19:0] LFSR20_LOCKUP = 20'hFFFFF;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } lfsr_state_e;

   // XNOR taps feed back bit 19 into positions 14, 8 and 4.
   function automatic logic [19:0] lfsr20_next(input logic [19:0] d);
      return {d[18:14], ~(d[19] ^ d[13]), d[12:8], ~(d[19] ^ d[7]),
              d[6:4], ~(d[19] ^ d[3]), d[2:0], d[19]};
   endfunction

endpackage

// File: rtl/popcount20.sv
// Combinational population count of a 20-bit word.
module popcount20 (
   input  logic [19:0] i_data,
   output logic [4:0]  o_count
);

   always_comb begin
      o_count = 5'd0;
      for (int i = 0; i < 20; i++) begin
         o_count = o_count + 5'(i_data[i]);
      end
   end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises to the LFSR20 stream, then
// free-runs its own predictor and reports per-word and accumulated bit errors.
module lfsr_checker
   import lfsr20_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 8,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [19:0]      data_in,
   input  logic             data_valid,
   output logic             locked,
   output logic             err_valid,
   output logic [4:0]       err_bits,
   output logic [CNT_W-1:0] word_err_count,
   output logic [CNT_W-1:0] bit_err_count
);

   lfsr_state_e      r_state;
   logic [19:0]      r_prev;
   logic             r_prev_ok;
   logic [3:0]       r_match_run;
   logic [3:0]       r_miss_run;
   logic [19:0]      r_expected;
   logic             r_err_valid;
   logic [4:0]       r_err_bits;
   logic [CNT_W-1:0] r_word_cnt;
   logic [CNT_W-1:0] r_bit_cnt;

   logic [19:0]      w_next_prev;
   logic [19:0]      w_next_data;
   logic [19:0]      w_next_exp;
   logic [4:0]       w_pop;
   logic             w_is_lockup;
   logic             w_seq_ok;
   logic [3:0]       w_match_run_nx;
   logic             w_lock_hit;
   logic             w_miss;
   logic [3:0]       w_miss_run_nx;
   logic             w_loss_hit;
   logic             w_count;
   logic [CNT_W+5:0] w_bit_sum;
   logic [CNT_W-1:0] w_bit_next;

   assign w_next_prev = lfsr20_next(r_prev);
   assign w_next_data = lfsr20_next(data_in);
   assign w_next_exp  = lfsr20_next(r_expected);

   popcount20 u_popcount (
      .i_data  (data_in ^ r_expected),
      .o_count (w_pop)
   );

   // A lock-up word can never extend a run, even if it follows itself.
   assign w_is_lockup    = (data_in == LFSR20_LOCKUP);
   assign w_seq_ok       = r_prev_ok && (data_in == w_next_prev) && !w_is_lockup;
   assign w_match_run_nx = w_seq_ok ? (r_match_run + 4'd1) : 4'd0;
   assign w_lock_hit     = (w_match_run_nx == 4'(LOCK_COUNT));

   assign w_miss         = (w_pop != 5'd0);
   assign w_miss_run_nx  = r_miss_run + 4'd1;
   assign w_loss_hit     = w_miss && (w_miss_run_nx == 4'(LOSS_COUNT));

   assign w_count        = data_valid && (r_state == LOCKED) && w_miss;

   // Extra headroom bits detect overflow of the bit counter, including CNT_W < 5.
   assign w_bit_sum  = {6'd0, r_bit_cnt} + {{(CNT_W+1){1'b0}}, w_pop};
   assign w_bit_next = (w_bit_sum[CNT_W+5:CNT_W] != 6'd0) ? {CNT_W{1'b1}}
                                                          : w_bit_sum[CNT_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= SEARCH;
         r_prev      <= 20'd0;
         r_prev_ok   <= 1'b0;
         r_match_run <= 4'd0;
         r_miss_run  <= 4'd0;
         r_expected  <= 20'd0;
         r_err_valid <= 1'b0;
         r_err_bits  <= 5'd0;
      end else begin
         r_err_valid <= 1'b0;
         if (data_valid) begin
            if (r_state == SEARCH) begin
               r_prev      <= data_in;
               r_prev_ok   <= !w_is_lockup;
               r_match_run <= w_match_run_nx;
               if (w_lock_hit) begin
                  r_state    <= LOCKED;
                  r_expected <= w_next_data;
                  r_miss_run <= 4'd0;
               end
            end else begin
               // Predictor advances regardless of the compare so errors stay isolated.
               r_err_valid <= 1'b1;
               r_err_bits  <= w_pop;
               r_expected  <= w_next_exp;
               if (w_miss) begin
                  r_miss_run <= w_miss_run_nx;
                  if (w_loss_hit) begin
                     r_state     <= SEARCH;
                     r_match_run <= 4'd0;
                     r_prev_ok   <= 1'b0;
                  end
               end else begin
                  r_miss_run <= 4'd0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_word_cnt <= '0;
         r_bit_cnt  <= '0;
      end else if (clear) begin
         r_word_cnt <= '0;
         r_bit_cnt  <= '0;
      end else if (w_count) begin
         if (!(&r_word_cnt)) begin
            r_word_cnt <= r_word_cnt + CNT_W'(1);
         end
         r_bit_cnt <= w_bit_next;
      end
   end

   assign locked         = (r_state == LOCKED);
   assign err_valid      = r_err_valid;
   assign err_bits       = r_err_bits;
   assign word_err_count = r_word_cnt;
   assign bit_err_count  = r_bit_cnt;

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomized self-checking bench for lfsr_checker: two instances (wide and
// 4-bit counters) share one stimulus stream and are compared to a word-level model.
module tb_lfsr_checker;

   localparam int LOCK_N = 4;
   localparam int LOSS_N = 8;
   localparam logic [19:0] LOCKUP = 20'hFFFFF;

   logic        clk;
   logic        reset;
   logic        clear;
   logic [19:0] data_in;
   logic        data_valid;

   logic        locked, err_valid;
   logic [4:0]  err_bits;
   logic [31:0] word_err_count, bit_err_count;

   logic        locked_s, err_valid_s;
   logic [4:0]  err_bits_s;
   logic [3:0]  word_err_count_s, bit_err_count_s;

   int n_checks = 0;
   int n_errors = 0;

   lfsr_checker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .clear(clear), .data_in(data_in),
      .data_valid(data_valid), .locked(locked), .err_valid(err_valid),
      .err_bits(err_bits), .word_err_count(word_err_count),
      .bit_err_count(bit_err_count)
   );

   lfsr_checker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N), .CNT_W(4)) dut_s (
      .clk(clk), .reset(reset), .clear(clear), .data_in(data_in),
      .data_valid(data_valid), .locked(locked_s), .err_valid(err_valid_s),
      .err_bits(err_bits_s), .word_err_count(word_err_count_s),
      .bit_err_count(bit_err_count_s)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   bit          m_locked;
   bit          m_err_valid;
   int          m_err_bits;
   logic [19:0] m_exp;
   int          m_miss;
   longint      m_w, m_b;
   logic [19:0] m_chain[$];
   logic [4:0]  exp_q[$];
   logic [19:0] g;

   // Galois step: rotate left, then invert taps 14/8/4 when the feedback bit is 0.
   function automatic logic [19:0] ref_next(input logic [19:0] d);
      logic [19:0] t;
      t = {d[18:0], d[19]};
      if (d[19] == 1'b0) begin
         t[14] = ~t[14];
         t[8]  = ~t[8];
         t[4]  = ~t[4];
      end
      return t;
   endfunction

   function automatic longint sat(input longint x, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (x > mx) ? mx : x;
   endfunction

   task automatic model_reset();
      m_locked = 0; m_err_valid = 0; m_err_bits = 0; m_exp = '0;
      m_miss = 0; m_w = 0; m_b = 0;
      m_chain.delete();
      exp_q.delete();
   endtask

   // SEARCH keeps the current chain of words linked by the step function;
   // lock once the chain holds LOCK_N+1 words.
   task automatic model_step(input bit v, input logic [19:0] d, input bit clr);
      int e;
      m_err_valid = 0;
      if (v) begin
         if (!m_locked) begin
            if (m_chain.size() != 0 && d == ref_next(m_chain[$])) m_chain.push_back(d);
            else begin
               m_chain.delete();
               m_chain.push_back(d);
            end
            if (d == LOCKUP) m_chain.delete();
            if (m_chain.size() == LOCK_N + 1) begin
               m_locked = 1;
               m_exp = ref_next(d);
               m_miss = 0;
            end
         end else begin
            e = $countones(d ^ m_exp);
            m_err_valid = 1;
            m_err_bits = e;
            exp_q.push_back(5'(e));
            m_exp = ref_next(m_exp);
            if (e != 0) begin
               m_w++;
               m_b += e;
               m_miss++;
               if (m_miss == LOSS_N) begin
                  m_locked = 0;
                  m_chain.delete();
               end
            end else begin
               m_miss = 0;
            end
         end
      end
      if (clr) begin
         m_w = 0;
         m_b = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // scoreboard
   task automatic check_outputs();
      logic [4:0] e;
      chk("locked", 64'(locked), 64'(m_locked));
      chk("locked_s", 64'(locked_s), 64'(m_locked));
      chk("err_valid", 64'(err_valid), 64'(m_err_valid));
      chk("err_valid_s", 64'(err_valid_s), 64'(m_err_valid));
      if (err_valid === 1'b1) begin
         chk("err_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("err_bits_pulse", 64'(err_bits), 64'(e));
         end
      end
      chk("err_bits_hold", 64'(err_bits), 64'(m_err_bits));
      chk("err_bits_s", 64'(err_bits_s), 64'(m_err_bits));
      chk("word_cnt", 64'(word_err_count), 64'(sat(m_w, 32)));
      chk("bit_cnt", 64'(bit_err_count), 64'(sat(m_b, 32)));
      chk("word_cnt_s", 64'(word_err_count_s), 64'(sat(m_w, 4)));
      chk("bit_cnt_s", 64'(bit_err_count_s), 64'(sat(m_b, 4)));
   endtask

   // driver tasks
   task automatic step(input bit v, input logic [19:0] d, input bit clr);
      data_valid = v;
      data_in    = d;
      clear      = clr;
      @(posedge clk);
      model_step(v, d, clr);
      #1;
      check_outputs();
   endtask

   task automatic send_clean();
      step(1'b1, g, 1'b0);
      g = ref_next(g);
   endtask

   task automatic send_err(input logic [19:0] mask, input bit clr);
      step(1'b1, g ^ mask, clr);
      g = ref_next(g);
   endtask

   task automatic stall();
      step(1'b0, 20'($urandom), 1'b0);
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      model_reset();
      chk("rst_locked", 64'(locked), 64'd0);
      chk("rst_err_valid", 64'(err_valid), 64'd0);
      chk("rst_err_bits", 64'(err_bits), 64'd0);
      chk("rst_word_cnt", 64'(word_err_count), 64'd0);
      chk("rst_bit_cnt", 64'(bit_err_count), 64'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic [19:0] rand_mask();
      if ($urandom_range(0, 1) == 0) return 20'd1 << $urandom_range(0, 19);
      return 20'($urandom_range(1, 20'hFFFFF));
   endfunction

   initial begin
      int r;
      reset = 1'b1; clear = 1'b0; data_valid = 1'b0; data_in = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
      reset = 1'b0;

      // clean lock from seed 1
      g = 20'h00001;
      for (int i = 0; i < LOCK_N; i++) send_clean();
      chk("not_locked_after_4", 64'(locked), 64'd0);
      send_clean();
      chk("locked_after_5", 64'(locked), 64'd1);
      for (int i = 0; i < 10; i++) send_clean();

      // single-bit error on bit 7
      send_err(20'h00080, 1'b0);
      chk("single_err_bits", 64'(err_bits), 64'd1);
      chk("single_word_cnt", 64'(word_err_count), 64'd1);
      chk("single_bit_cnt", 64'(bit_err_count), 64'd1);
      send_clean();
      chk("after_single_err_bits", 64'(err_bits), 64'd0);
      chk("after_single_locked", 64'(locked), 64'd1);

      // loss of lock and re-lock
      for (int i = 0; i < LOSS_N - 1; i++) send_err(rand_mask(), 1'b0);
      chk("still_locked_7_miss", 64'(locked), 64'd1);
      send_err(rand_mask(), 1'b0);
      chk("lost_lock", 64'(locked), 64'd0);
      chk("loss_word_cnt", 64'(word_err_count), 64'd9);
      for (int i = 0; i < LOCK_N + 1; i++) send_clean();
      chk("relock", 64'(locked), 64'd1);

      // valid gaps with the generator stalled
      for (int i = 0; i < 4; i++) begin
         send_clean();
         stall();
         stall();
         send_clean();
      end

      // saturation of the 4-bit counters; clean words keep the lock
      for (int i = 0; i < 20; i++) begin
         send_err(rand_mask(), 1'b0);
         send_clean();
      end
      chk("sat_word_s", 64'(word_err_count_s), 64'hF);
      chk("sat_bit_s", 64'(bit_err_count_s), 64'hF);
      send_err(rand_mask(), 1'b1);
      chk("clear_word", 64'(word_err_count), 64'd0);
      chk("clear_bit", 64'(bit_err_count), 64'd0);
      chk("clear_word_s", 64'(word_err_count_s), 64'd0);
      chk("clear_locked", 64'(locked), 64'd1);

      // lock-up word from reset never locks
      async_reset();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0) step(1'b0, LOCKUP, 1'b0);
         else step(1'b1, LOCKUP, 1'b0);
      end
      chk("lockup_unlocked", 64'(locked), 64'd0);
      chk("lockup_word_cnt", 64'(word_err_count), 64'd0);

      // mid-stream reset then normal re-lock
      g = 20'($urandom_range(0, 20'hFFFFE));
      for (int i = 0; i < 12; i++) send_clean();
      async_reset();
      for (int i = 0; i < 8; i++) send_clean();

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         r = $urandom_range(0, 299);
         if (r < 3) async_reset();
         else if (r < 40) stall();
         else if (r < 80) send_err(rand_mask(), 1'b0);
         else if (r < 86) begin
            g = 20'($urandom_range(0, 20'hFFFFE));
            send_clean();
         end else if (r < 90) begin
            step(1'b1, LOCKUP, 1'b0);
            g = ref_next(g);
         end else if (r < 95) send_err(rand_mask(), 1'b1);
         else if (r < 100) begin
            step(1'b1, g, 1'b1);
            g = ref_next(g);
         end else send_clean();
      end

      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
